// File: rtl/rom_loader_if.sv
// Memory write bus between rom_loader (master) and the memory controller (slave).
// Request is a level held until a one-cycle ack; addr/din are stable while mem_req is high.
interface rom_loader_if #(
    parameter int ADDR_W = 22
) ();
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_din;
    logic              mem_ack;

    modport master (
        output mem_req,
        output mem_addr,
        output mem_din,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        input  mem_din,
        output mem_ack
    );
endinterface

// File: rtl/rom_loader.sv
// Packs the streamed ROM bytes into little-endian 16-bit words and writes them through a small FIFO.
// Optional feature macro: ROM_LOADER_HEADER_SKIP_EN (discard a 512-byte copier header on request).
module rom_loader #(
    parameter int ADDR_W     = 22,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rom_loading,
    input  logic [7:0]  rom_do,
    input  logic        rom_do_valid,
    input  logic        skip_header,
    rom_loader_if.master mem,
    output logic [23:0] rom_size,
    output logic        loading_done,
    output logic        overflow
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic              r_loading_d;
    logic              r_phase;
    logic [7:0]        r_lo;
    logic [15:0]       r_word;
    logic              r_word_vld;
    logic [23:0]       r_rom_size;
    logic              r_overflow;
    logic              r_done;

    logic [15:0]       r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wp;
    logic [PTR_W-1:0]  r_rp;
    logic [CNT_W-1:0]  r_cnt;

    logic              r_req;
    logic [ADDR_W-1:0] r_addr;
    logic [15:0]       r_din;

    logic w_rise, w_fall;
    logic w_byte, w_skip, w_accept;
    logic w_start, w_pad, w_done;
    logic w_full, w_empty, w_push, w_pop, w_drop;

    assign w_rise = rom_loading & ~r_loading_d;
    assign w_fall = ~rom_loading & r_loading_d;
    assign w_byte = (r_state == S_LOAD) & rom_loading & rom_do_valid;

`ifdef ROM_LOADER_HEADER_SKIP_EN
    logic       r_skip_en;
    logic [9:0] r_skip_cnt;

    assign w_skip = r_skip_en & (r_skip_cnt != 10'd512);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_skip_en  <= 1'b0;
            r_skip_cnt <= '0;
        end else if (w_start) begin
            r_skip_en  <= skip_header;
            r_skip_cnt <= '0;
        end else if (w_byte && w_skip) begin
            r_skip_cnt <= r_skip_cnt + 10'd1;
        end
    end
`else
    logic w_unused_skip;
    assign w_unused_skip = skip_header;
    assign w_skip        = 1'b0;
`endif

    assign w_accept = w_byte & ~w_skip;

    assign w_full  = (r_cnt == CNT_W'(FIFO_DEPTH));
    assign w_empty = (r_cnt == '0);
    assign w_pop   = r_req & mem.mem_ack;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_push  = r_word_vld & (~w_full | w_pop);
    assign w_drop  = r_word_vld & w_full & ~w_pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_pad       = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rise) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_fall) begin
                    w_pad       = r_phase;
                    w_state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                // Wait for the last (possibly padded) word to be pushed and fully written.
                if (w_empty && !r_req && !r_word_vld) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_loading_d <= 1'b0;
            r_phase     <= 1'b0;
            r_lo        <= '0;
            r_word      <= '0;
            r_word_vld  <= 1'b0;
            r_rom_size  <= '0;
            r_done      <= 1'b0;
        end else begin
            r_loading_d <= rom_loading;
            r_done      <= w_done;
            r_word_vld  <= 1'b0;
            if (w_start) begin
                r_phase    <= 1'b0;
                r_rom_size <= '0;
            end else if (w_accept) begin
                r_rom_size <= r_rom_size + 24'd1;
                if (!r_phase) begin
                    r_lo    <= rom_do;
                    r_phase <= 1'b1;
                end else begin
                    r_word     <= {rom_do, r_lo};
                    r_word_vld <= 1'b1;
                    r_phase    <= 1'b0;
                end
            end else if (w_pad) begin
                r_word     <= {8'h00, r_lo};
                r_word_vld <= 1'b1;
                r_phase    <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wp] <= r_word;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wp       <= '0;
            r_rp       <= '0;
            r_cnt      <= '0;
            r_overflow <= 1'b0;
        end else if (w_start) begin
            r_wp       <= '0;
            r_rp       <= '0;
            r_cnt      <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push)
                r_wp <= (r_wp == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_wp + PTR_W'(1);
            if (w_pop)
                r_rp <= (r_rp == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_rp + PTR_W'(1);
            if (w_push && !w_pop)
                r_cnt <= r_cnt + CNT_W'(1);
            else if (w_pop && !w_push)
                r_cnt <= r_cnt - CNT_W'(1);
            if (w_drop)
                r_overflow <= 1'b1;
        end
    end

    // The head stays in the FIFO until acked; mem_req drops for a cycle after every ack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_req  <= 1'b0;
            r_addr <= '0;
            r_din  <= '0;
        end else begin
            if (w_start)
                r_addr <= '0;
            if (w_pop) begin
                r_req  <= 1'b0;
                r_addr <= r_addr + ADDR_W'(1);
            end else if (!r_req && !w_empty) begin
                r_req <= 1'b1;
                r_din <= r_fifo[r_rp];
            end
        end
    end

    assign mem.mem_req   = r_req;
    assign mem.mem_addr  = r_addr;
    assign mem.mem_din   = r_din;
    assign rom_size      = r_rom_size;
    assign loading_done  = r_done;
    assign overflow      = r_overflow;
endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader: byte pairing, padding, overflow, reset abort, address wrap.
module tb_rom_loader;
    logic        clk = 1'b0;
    logic        reset;
    logic        rom_loading;
    logic [7:0]  rom_do;
    logic        rom_do_valid;
    logic        skip_header;
    logic [23:0] rom_size;
    logic        loading_done;
    logic        overflow;

    logic        ack_en;
    int          done_cnt;
    int          passed;
    int          fails;
    int          total;
    logic [3:0]  wr_addr [$];
    logic [15:0] wr_din  [$];

    rom_loader_if #(.ADDR_W(4)) mem_bus ();

    rom_loader #(.ADDR_W(4), .FIFO_DEPTH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .rom_loading  (rom_loading),
        .rom_do       (rom_do),
        .rom_do_valid (rom_do_valid),
        .skip_header  (skip_header),
        .mem          (mem_bus),
        .rom_size     (rom_size),
        .loading_done (loading_done),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    // Memory controller model: one-cycle ack to each request, logging the write.
    initial begin
        mem_bus.mem_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (ack_en && mem_bus.mem_req && !mem_bus.mem_ack) begin
                wr_addr.push_back(mem_bus.mem_addr);
                wr_din.push_back(mem_bus.mem_din);
                mem_bus.mem_ack = 1'b1;
            end else begin
                mem_bus.mem_ack = 1'b0;
            end
        end
    end

    initial begin
        done_cnt = 0;
        forever begin
            @(negedge clk);
            if (loading_done) done_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_wr(input int k, input logic [3:0] addr, input logic [15:0] din);
        if (wr_din.size() > k) begin
            chk($sformatf("wr%0d_addr", k), 32'(wr_addr[k]), 32'(addr));
            chk($sformatf("wr%0d_din", k), 32'(wr_din[k]), 32'(din));
        end else begin
            chk($sformatf("wr%0d_missing", k), 32'(wr_din.size()), 32'(k + 1));
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rom_do       = b;
        rom_do_valid = 1'b1;
        @(negedge clk);
        rom_do_valid = 1'b0;
    endtask

    task automatic start_session(input logic skip);
        @(negedge clk);
        skip_header = skip;
        rom_loading = 1'b1;
        wr_addr.delete();
        wr_din.delete();
        done_cnt = 0;
        @(negedge clk);
    endtask

    task automatic end_session();
        @(negedge clk);
        rom_loading = 1'b0;
        for (int i = 0; i < 300 && done_cnt == 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("done_pulses", 32'(done_cnt), 32'd1);
    endtask

    initial begin
        passed       = 0;
        fails        = 0;
        total        = 0;
        ack_en       = 1'b1;
        reset        = 1'b1;
        rom_loading  = 1'b0;
        rom_do       = 8'h00;
        rom_do_valid = 1'b0;
        skip_header  = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_req",      32'(mem_bus.mem_req),  32'd0);
        chk("rst_addr",     32'(mem_bus.mem_addr), 32'd0);
        chk("rst_din",      32'(mem_bus.mem_din),  32'd0);
        chk("rst_size",     32'(rom_size),         32'd0);
        chk("rst_done",     32'(loading_done),     32'd0);
        chk("rst_overflow", 32'(overflow),         32'd0);

        // Four bytes, immediate ack
        start_session(1'b0);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        end_session();
        chk("s1_nwr", 32'(wr_din.size()), 32'd2);
        chk_wr(0, 4'd0, 16'h2211);
        chk_wr(1, 4'd1, 16'h4433);
        chk("s1_size", 32'(rom_size), 32'd4);

        // Strobe outside a session is ignored
        send(8'hEE);
        chk("idle_byte_size", 32'(rom_size), 32'd4);

        // Odd byte count gets padded
        start_session(1'b0);
        send(8'hAA); send(8'hBB); send(8'hCC);
        end_session();
        chk("s2_nwr", 32'(wr_din.size()), 32'd2);
        chk_wr(0, 4'd0, 16'hBBAA);
        chk_wr(1, 4'd1, 16'h00CC);
        chk("s2_size", 32'(rom_size), 32'd3);
        chk("s2_overflow", 32'(overflow), 32'd0);

        // Ack withheld: FIFO fills, two words dropped
        ack_en = 1'b0;
        start_session(1'b0);
        for (int i = 1; i <= 12; i++) send(8'(i));
        repeat (4) @(negedge clk);
        chk("s3_overflow", 32'(overflow), 32'd1);
        chk("s3_size", 32'(rom_size), 32'd12);
        chk("s3_req_held", 32'(mem_bus.mem_req), 32'd1);
        chk("s3_din_held", 32'(mem_bus.mem_din), 32'h0201);
        ack_en = 1'b1;
        end_session();
        chk("s3_nwr", 32'(wr_din.size()), 32'd4);
        chk_wr(0, 4'd0, 16'h0201);
        chk_wr(1, 4'd1, 16'h0403);
        chk_wr(2, 4'd2, 16'h0605);
        chk_wr(3, 4'd3, 16'h0807);
        chk("s3_overflow_sticky", 32'(overflow), 32'd1);

`ifdef ROM_LOADER_HEADER_SKIP_EN
        start_session(1'b1);
        for (int i = 0; i < 512; i++) send(8'hFF);
        send(8'h5A); send(8'hA5);
        end_session();
        chk("skip_nwr", 32'(wr_din.size()), 32'd1);
        chk_wr(0, 4'd0, 16'hA55A);
        chk("skip_size", 32'(rom_size), 32'd2);
`else
        start_session(1'b1);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        end_session();
        chk("noskip_nwr", 32'(wr_din.size()), 32'd2);
        chk_wr(0, 4'd0, 16'h0201);
        chk_wr(1, 4'd1, 16'h0403);
        chk("noskip_size", 32'(rom_size), 32'd4);
`endif
        chk("new_session_clears_ovf", 32'(overflow), 32'd0);

        // Reset while a request is outstanding
        ack_en = 1'b0;
        start_session(1'b0);
        send(8'h12); send(8'h34);
        for (int i = 0; i < 20 && !mem_bus.mem_req; i++) @(negedge clk);
        chk("pre_rst_req", 32'(mem_bus.mem_req), 32'd1);
        chk("pre_rst_din", 32'(mem_bus.mem_din), 32'h3412);
        @(negedge clk);
        #2;
        reset       = 1'b1;
        rom_loading = 1'b0;
        #1;
        chk("arst_req",  32'(mem_bus.mem_req),  32'd0);
        chk("arst_din",  32'(mem_bus.mem_din),  32'd0);
        chk("arst_size", 32'(rom_size),         32'd0);
        chk("arst_done", 32'(loading_done),     32'd0);
        chk("arst_ovf",  32'(overflow),         32'd0);
        @(negedge clk);
        reset  = 1'b0;
        ack_en = 1'b1;
        start_session(1'b0);
        send(8'h77); send(8'h66);
        end_session();
        chk("post_rst_nwr", 32'(wr_din.size()), 32'd1);
        chk_wr(0, 4'd0, 16'h6677);

        // 17 words with a 4-bit address: the last wraps to 0
        start_session(1'b0);
        for (int i = 0; i < 17; i++) begin
            send(8'(i));
            send(8'(8'h80 | 8'(i)));
        end
        end_session();
        chk("wrap_nwr", 32'(wr_din.size()), 32'd17);
        chk_wr(15, 4'd15, 16'h8F0F);
        chk_wr(16, 4'd0,  16'h9010);
        chk("wrap_size", 32'(rom_size), 32'd34);
        chk("wrap_ovf", 32'(overflow), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/rom_loader.md
ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 22, giving the width of the 16-bit-word memory address.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, giving the number of word FIFO entries (power of 2).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port rom_loading, input, 1 bit: load-session level from the SPI system block.
REQ-006 The block SHALL have port rom_do, input, 8 bits: the ROM data byte.
REQ-007 The block SHALL have port rom_do_valid, input, 1 bit: one-cycle strobe that qualifies rom_do.
REQ-008 The block SHALL have port skip_header, input, 1 bit: request to discard the 512-byte copier header.
REQ-009 The block SHALL have port mem_req, output, 1 bit: write request level, held until acknowledged.
REQ-010 The block SHALL have port mem_addr, output, ADDR_W bits: word address of the current write.
REQ-011 The block SHALL have port mem_din, output, 16 bits: write data, {high byte, low byte}.
REQ-012 The block SHALL have port mem_ack, input, 1 bit: one-cycle write acknowledge from the memory controller.
REQ-013 The block SHALL have port rom_size, output, 24 bits: count of accepted (non-skipped) bytes.
REQ-014 The block SHALL have port loading_done, output, 1 bit: one-cycle pulse when all words have been written.
REQ-015 The block SHALL have port overflow, output, 1 bit: sticky flag indicating a word was dropped because the FIFO was full.

Function
REQ-016 The main FSM SHALL have three states: IDLE, LOAD, FLUSH.
REQ-017 In IDLE, a rising edge of rom_loading SHALL clear rom_size, the address, the byte phase, the FIFO, overflow and the skip counter, sample skip_header, and move the FSM to LOAD.
REQ-018 In LOAD, each rom_do_valid SHALL accept one byte; bytes pair little-endian (first byte goes to mem_din[7:0], second to mem_din[15:8]).
REQ-019 The completed word SHALL enter the FIFO in the cycle after the second byte's strobe.
REQ-020 rom_size SHALL increment by 1 for every accepted byte and wrap at 2^24.
REQ-021 rom_do_valid SHALL be ignored in IDLE and FLUSH, and whenever rom_loading=0.
REQ-022 A falling edge of rom_loading in LOAD SHALL push a pad word {8'h00, low byte} if one byte is pending, then move the FSM to FLUSH.
REQ-023 In FLUSH, once the FIFO is empty and no request is outstanding, the block SHALL pulse loading_done for one cycle and return to IDLE.
REQ-024 The write side SHALL assert mem_req in the cycle after the FIFO becomes non-empty, with mem_addr and mem_din stable while mem_req is high.
REQ-025 On mem_ack sampled high, the block SHALL pop the FIFO, increment mem_addr, and drive mem_req low for at least one cycle; the earliest next mem_req is the cycle after that.
REQ-026 mem_ack while mem_req=0 SHALL be ignored.
REQ-027 mem_addr SHALL wrap from 2^ADDR_W-1 to 0 without flagging an error.
REQ-028 A word completing while the FIFO is full SHALL be dropped, overflow SHALL be set, and rom_size SHALL still count the byte.
REQ-029 A push and a pop in the same cycle SHALL keep the FIFO occupancy unchanged.
REQ-030 A rising edge of rom_loading outside IDLE SHALL be ignored.

Reset
REQ-031 reset SHALL immediately force IDLE, mem_req=0, mem_addr=0, mem_din=0, rom_size=0, loading_done=0, overflow=0, FIFO empty and byte phase 0.
REQ-032 Reset mid-transfer SHALL abandon any outstanding request without waiting for mem_ack.

Configuration
REQ-033 With ROM_LOADER_HEADER_SKIP_EN defined and skip_header=1 sampled at session start, the first 512 bytes SHALL be discarded, not written and not counted in rom_size, and pairing SHALL start at byte 512.
REQ-034 Without ROM_LOADER_HEADER_SKIP_EN, skip_header SHALL be present but ignored, and all bytes SHALL be written.

Verification
REQ-035 Bytes 11,22,33,44 with immediate ack -> writes addr0=0x2211, addr1=0x4433; rom_size=4; one loading_done pulse.
REQ-036 Three bytes AA,BB,CC, then rom_loading falls -> second write is addr1=0x00CC; rom_size=3.
REQ-037 mem_ack withheld while 12 bytes are streamed with FIFO_DEPTH=4 -> overflow=1; 4 words are written after ack resumes; rom_size=12.
REQ-038 Macro defined, skip_header=1, 514 bytes (last two 0x5A,0xA5) -> a single write addr0=0xA55A; rom_size=2.
REQ-039 reset pulsed while mem_req=1 -> mem_req=0 asynchronously; all outputs 0; the next session starts at addr0.
REQ-040 Start ADDR_W=4 at 15 words written, write 2 more words -> the second word lands at addr 0; overflow=0.
